compare4a_checker: RTL and testbench
====================================

Name: compare4a_checker

Overview:
- Self-checking stimulus/response engine for the compare4a magnitude comparator.
- Drives every (a,b) operand pair into a comparator instance and consumes its y code.
- Checks each response against an internal reference and reports pass/fail, error count and first failing pair.
- Sits beside the comparator on the board/bench as the producer of a/b and the consumer of y.

Parameters:
- WIDTH, 4, operand width; the sweep covers 2^(2*WIDTH) pairs.
- SETTLE, 2, extra cycles each pair is held before y is sampled (≥0).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sweep; sampled in IDLE only
- a_out  out  WIDTH  operand a to comparator
- b_out  out  WIDTH  operand b to comparator
- y_in  in  3  comparator result; y[2]=a>b, y[1]=a==b, y[0]=a<b (exactly one-hot)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the sweep ends
- pass  out  1  high when the last sweep had zero mismatches; held until the next start
- err_count  out  2*WIDTH+1  mismatches in the current/last sweep
- first_err_a  out  WIDTH  a of the first mismatch (0 if none)
- first_err_b  out  WIDTH  b of the first mismatch (0 if none)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - a_out, b_out, busy, done, pass, err_count, first_err_a and first_err_b all 0.
  - Reset mid-sweep aborts immediately; no done pulse is generated.
- FSM: IDLE -> HOLD -> CHECK -> (HOLD | FIN) -> IDLE.
- IDLE:
  - start=1 loads a_out=b_out=0.
  - Clears err_count, pass, first_err_a and first_err_b.
  - Loads settle counter with SETTLE, then goes to HOLD.
  - start is ignored in every other state.
- HOLD: counter decrements each cycle; when it equals 0, go to CHECK.
- CHECK:
  - Sample y_in and compare it with expected {a>b, a==b, a<b} (unsigned).
  - Mismatch (including any non-one-hot y_in) increments err_count.
  - On the first mismatch, also latch first_err_a/b.
  - If {a_out,b_out} is all ones, go to FIN.
  - Otherwise increment the 2*WIDTH-bit pair counter {a_out,b_out}, with b the low half and b wrap carrying into a.
  - Reload the settle counter and return to HOLD.
- Pair timing: each pair is presented SETTLE+1 cycles before sampling.
  - Start-accept to FIN = 2^(2*WIDTH)*(SETTLE+2) cycles.
  - That is 1024 cycles for the defaults.
- FIN:
  - done=1 for one cycle; pass=(err_count==0); busy=0.
  - a_out/b_out hold the last pair; go to IDLE.
- busy=1 in HOLD and CHECK.
- err_count cannot overflow: its width covers 2^(2*WIDTH) errors.

Optional Feature:
- Macro COMPARE4A_CHK_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes directly to FIN.
  - done pulses, pass=0, err_count=1.
  - a_out/b_out remain at the failing pair.
- Undefined: the full sweep always runs and all mismatches are counted.

Decomposition:
- Shared package compare4a_pkg holds:
  - the state enum (IDLE, HOLD, CHECK, FIN);
  - y bit-index constants Y_GT=2, Y_EQ=1, Y_LT=0.
- The same package is reused by compare4a itself.
- One sub-module, compare4a_ref: a combinational golden comparator (a, b -> expected y) instantiated by the checker.

Test Plan:
- Correct compare4a connected, SETTLE=2, start pulsed -> busy for 1024 cycles, one done pulse, pass=1, err_count=0, first_err_a/b=0.
- Faulty model forcing y=3'b000 only at a=4'b1010, b=4'b1100 -> err_count=1, pass=0, first_err_a=10, first_err_b=12.
- Faulty model with eq bit stuck at 0 -> err_count=16, first_err_a=0, first_err_b=0, pass=0.
- start re-pulsed mid-sweep at pair (3,7) -> ignored; done still at cycle 1024, err_count unaffected.
- rst_n low for 1 cycle mid-sweep -> all outputs 0 asynchronously, state IDLE, no done; a later start yields a full clean sweep.
- COMPARE4A_CHK_STOP_ON_ERR_EN defined, eq stuck-at-0 -> done after pair (0,0) CHECK (cycle 4), err_count=1, a_out=b_out=0, pass=0.

Source files
------------

// File: rtl/compare4a_pkg.sv
// rtl/compare4a_pkg.sv - shared types and constants for the compare4a comparator family
//
// state_t : checker FSM states (IDLE, HOLD, CHECK, FIN)
// Y_GT/Y_EQ/Y_LT : bit positions inside the 3-bit one-hot y code
package compare4a_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int Y_GT = 2;
  localparam int Y_EQ = 1;
  localparam int Y_LT = 0;

endpackage

// File: rtl/compare4a_ref.sv
// rtl/compare4a_ref.sv - combinational golden magnitude comparator
//
// a [WIDTH] : operand a (unsigned)
// b [WIDTH] : operand b (unsigned)
// y [3]     : one-hot result {a>b, a==b, a<b}
module compare4a_ref
  import compare4a_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       y
);

  always_comb begin
    y       = 3'b000;
    y[Y_GT] = (a > b);
    y[Y_EQ] = (a == b);
    y[Y_LT] = (a < b);
  end

endmodule

// File: rtl/compare4a_checker.sv
// rtl/compare4a_checker.sv - exhaustive stimulus/response checker for compare4a
//
// Optional build macro: COMPARE4A_CHK_STOP_ON_ERR_EN (end the sweep at the first mismatch)
//
// clk         : rising-edge clock
// rst_n       : asynchronous active-low reset
// start       : begin a sweep (sampled in IDLE only)
// a_out/b_out : operand pair driven to the comparator under test
// y_in        : comparator result {gt, eq, lt}
// busy        : high while the sweep runs (HOLD/CHECK)
// done        : one-cycle pulse when the sweep ends
// pass        : last sweep had zero mismatches, held until next start
// err_count   : mismatches in the current/last sweep
// first_err_a : a of the first mismatching pair (0 if none)
// first_err_b : b of the first mismatching pair (0 if none)
module compare4a_checker
  import compare4a_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic [2:0]         y_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_err_a,
  output logic [WIDTH-1:0]   first_err_b
);

  // Wide enough to hold SETTLE; never narrower than one bit when SETTLE=0.
  localparam int CW = $clog2(SETTLE + 2);
  localparam logic [CW-1:0] SETTLE_V = CW'(SETTLE);

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        y_exp;
  logic              mismatch;
  logic              last_pair;
  logic              stop_now;
  logic [2*WIDTH:0]  err_nxt;
  logic [2*WIDTH-1:0] pair_nxt;

  compare4a_ref #(.WIDTH(WIDTH)) u_ref (
    .a (a_out),
    .b (b_out),
    .y (y_exp)
  );

  // The reference is strictly one-hot, so any non-one-hot y_in also lands here.
  assign mismatch  = (y_in != y_exp);
  assign last_pair = &{a_out, b_out};
  assign err_nxt   = err_count + {{(2*WIDTH){1'b0}}, mismatch};
  // b is the low half, so a b wrap carries straight into a.
  assign pair_nxt  = {a_out, b_out} + {{(2*WIDTH-1){1'b0}}, 1'b1};

`ifdef COMPARE4A_CHK_STOP_ON_ERR_EN
  assign stop_now = last_pair | mismatch;
`else
  assign stop_now = last_pair;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = HOLD;
      HOLD:  if (cnt == '0) state_nxt = CHECK;
      CHECK: state_nxt = stop_now ? FIN : HOLD;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      HOLD, CHECK: busy = 1'b1;
      FIN:         done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand counter, settle counter, result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out       <= '0;
      b_out       <= '0;
      cnt         <= '0;
      pass        <= 1'b0;
      err_count   <= '0;
      first_err_a <= '0;
      first_err_b <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_out       <= '0;
            b_out       <= '0;
            cnt         <= SETTLE_V;
            pass        <= 1'b0;
            err_count   <= '0;
            first_err_a <= '0;
            first_err_b <= '0;
          end
        end
        HOLD: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        CHECK: begin
          err_count <= err_nxt;
          if (mismatch && (err_count == '0)) begin
            first_err_a <= a_out;
            first_err_b <= b_out;
          end
          // pass is settled on the way into FIN so it is valid alongside done.
          if (stop_now) begin
            pass <= (err_nxt == '0);
          end else begin
            {a_out, b_out} <= pair_nxt;
            cnt            <= SETTLE_V;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_compare4a_checker.sv
// tb/tb_compare4a_checker.sv - directed self-checking bench for compare4a_checker
module tb_compare4a_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [2:0] y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [3:0] first_err_a;
  logic [3:0] first_err_b;

  int fault;
  int errors = 0;
  int checks = 0;
  int n;
  int bc;
  int dcount;

  always #5 clk = ~clk;

  compare4a_checker #(.WIDTH(4), .SETTLE(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_out       (a_out),
    .b_out       (b_out),
    .y_in        (y_in),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b)
  );

  // Behavioural compare4a with selectable faults:
  // 0 = correct, 1 = y forced to 000 at (10,12), 2 = eq bit stuck at 0
  always_comb begin
    y_in = {a_out > b_out, a_out == b_out, a_out < b_out};
    if (fault == 1 && a_out == 4'd10 && b_out == 4'd12) y_in = 3'b000;
    if (fault == 2) y_in[1] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start, then counts posedges after the accepting edge until done is seen.
  task automatic run_sweep(input bit mid_start, output int cyc, output int bcnt);
    bit pulsed;
    bit seen;
    pulsed = 0;
    seen   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    bcnt = busy ? 1 : 0;
    cyc  = 0;
    while (cyc < 2000 && !seen) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mid_start && !pulsed && a_out == 4'd3 && b_out == 4'd7) begin
        start  = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, a_out, 0);
    check({tag, "_b"}, b_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fa"}, first_err_a, 0);
    check({tag, "_fb"}, first_err_b, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fault = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // Clean sweep
    fault = 0;
    run_sweep(0, n, bc);
    check("clean_cycles", n, 1024);
    check("clean_busy_cycles", bc, 1024);
    check("clean_busy_at_done", busy, 0);
    check("clean_pass", pass, 1);
    check("clean_err", err_count, 0);
    check("clean_fa", first_err_a, 0);
    check("clean_fb", first_err_b, 0);
    check("clean_a_hold", a_out, 15);
    check("clean_b_hold", b_out, 15);
    @(negedge clk);
    check("clean_done_one_pulse", done, 0);
    check("clean_pass_held", pass, 1);

    // Single-point fault at (10,12)
    fault = 1;
    run_sweep(0, n, bc);
`ifdef COMPARE4A_CHK_STOP_ON_ERR_EN
    check("f1_cycles", n, 692);
    check("f1_a_stop", a_out, 10);
    check("f1_b_stop", b_out, 12);
`else
    check("f1_cycles", n, 1024);
`endif
    check("f1_err", err_count, 1);
    check("f1_pass", pass, 0);
    check("f1_fa", first_err_a, 10);
    check("f1_fb", first_err_b, 12);

    // eq stuck at 0
    fault = 2;
    run_sweep(0, n, bc);
`ifdef COMPARE4A_CHK_STOP_ON_ERR_EN
    check("eq0_cycles", n, 4);
    check("eq0_err", err_count, 1);
    check("eq0_a_stop", a_out, 0);
    check("eq0_b_stop", b_out, 0);
`else
    check("eq0_cycles", n, 1024);
    check("eq0_err", err_count, 16);
`endif
    check("eq0_pass", pass, 0);
    check("eq0_fa", first_err_a, 0);
    check("eq0_fb", first_err_b, 0);

    // start re-pulsed at pair (3,7) must be ignored
`ifdef COMPARE4A_CHK_STOP_ON_ERR_EN
    fault = 0;
`else
    fault = 2;
`endif
    run_sweep(1, n, bc);
    check("restart_cycles", n, 1024);
`ifdef COMPARE4A_CHK_STOP_ON_ERR_EN
    check("restart_err", err_count, 0);
    check("restart_pass", pass, 1);
`else
    check("restart_err", err_count, 16);
    check("restart_pass", pass, 0);
`endif

    // Asynchronous reset mid-sweep
    fault = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (busy) bc++;
    end
    check("midrst_no_done", dcount, 0);
    check("midrst_idle", bc, 0);

    fault = 0;
    run_sweep(0, n, bc);
    check("post_rst_cycles", n, 1024);
    check("post_rst_pass", pass, 1);
    check("post_rst_err", err_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
